// File: rtl/aoi22_bist_pkg.sv
// aoi22_bist_pkg
// Shared types and constants for the AOI22 self-test sequencer:
//   state_e    - sequencer FSM states
//   GOLDEN_ZN  - expected ZN per pattern index {A1,A2,B1,B2}
//   NUM_PAT    - number of exhaustive input patterns
//   golden_zn  - lookup of the expected ZN for one pattern index
package aoi22_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int NUM_PAT = 16;

  // Bit i is ~((A1&A2)|(B1&B2)) for {A1,A2,B1,B2} = i.
  localparam logic [NUM_PAT-1:0] GOLDEN_ZN = 16'h0777;

  function automatic logic golden_zn(input logic [3:0] pat);
    logic [NUM_PAT-1:0] tbl;
    tbl = GOLDEN_ZN;
    return tbl[pat];
  endfunction

endpackage

// File: rtl/aoi22_bist_seq.sv
// aoi22_bist_seq
// Pattern counter plus settle counter for the AOI22 self-test.
// Ports:
//   clk_i          - rising-edge clock
//   rst_ni         - asynchronous active-low reset
//   load_i         - run accepted: restart at pattern 0 with a full settle time
//   state_i        - current FSM state of the parent sequencer
//   pat_o          - current pattern index (flop output, drives the cell directly)
//   settle_done_o  - settle counter has reached zero
//   check_strobe_o - high during the one-cycle compare window
//   last_o         - current pattern is the final one
module aoi22_bist_seq
  import aoi22_bist_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  state_e     state_i,
  output logic [3:0] pat_o,
  output logic       settle_done_o,
  output logic       check_strobe_o,
  output logic       last_o
);

  // The counter starts at SETTLE_CYCLES-1 and the transition out of SETTLE
  // happens on the edge where it reads zero, giving exactly SETTLE_CYCLES
  // cycles of hold per pattern.
  localparam logic [3:0] RELOAD   = 4'(SETTLE_CYCLES - 1);
  localparam logic [3:0] LAST_PAT = 4'(NUM_PAT - 1);

  logic [3:0] pat_q, pat_d;
  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    pat_d = pat_q;
    cnt_d = cnt_q;
    if (load_i) begin
      pat_d = '0;
      cnt_d = RELOAD;
    end else begin
      case (state_i)
        ST_SETTLE: begin
          if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        end
        ST_CHECK: begin
          // No wrap: the final pattern stays on the cell after the run.
          if (pat_q != LAST_PAT) begin
            pat_d = pat_q + 4'd1;
            cnt_d = RELOAD;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pat_q <= '0;
      cnt_q <= '0;
    end else begin
      pat_q <= pat_d;
      cnt_q <= cnt_d;
    end
  end

  assign pat_o          = pat_q;
  assign settle_done_o  = (cnt_q == 4'd0);
  assign check_strobe_o = (state_i == ST_CHECK);
  assign last_o         = (pat_q == LAST_PAT);

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__aoi22_bist.sv
// gf180mcu_fd_sc_mcu9t5v0__aoi22_bist
// Exhaustive self-test sequencer for one aoi22 cell: drives all 16 input
// combinations, waits SETTLE_CYCLES per pattern, samples ZN_IN and compares it
// with the golden AOI22 response, then reports pass/fail.
// Ports:
//   CLK, RN            - clock, asynchronous active-low reset
//   START              - run request, honoured only in IDLE and DONE
//   ZN_IN              - response of the cell under test
//   A1, A2, B1, B2     - cell stimulus, {A1,A2,B1,B2} = pattern index
//   BUSY, DONE, PASS   - run status
//   ERR_CNT            - saturating mismatch count
//   FAIL_SEEN          - at least one mismatch in this run
//   FIRST_FAIL         - pattern index of the first mismatch
//   VDD, VSS           - supply pins, no logic function
module gf180mcu_fd_sc_mcu9t5v0__aoi22_bist
  import aoi22_bist_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 5
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             START,
  input  logic             ZN_IN,
  output logic             A1,
  output logic             A2,
  output logic             B1,
  output logic             B2,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [ERR_W-1:0] ERR_CNT,
  output logic             FAIL_SEEN,
  output logic [3:0]       FIRST_FAIL,
  inout  wire              VDD,
  inout  wire              VSS
);

  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  state_e           state_q;
  logic             busy_q;
  logic             done_q;
  logic [ERR_W-1:0] err_q;
  logic             fail_seen_q;
  logic [3:0]       first_fail_q;

  logic [3:0]       pat;
  logic             settle_done;
  logic             check_strobe;
  logic             last_pat;
  logic             accept;
  logic             mismatch;
  logic [ERR_W-1:0] err_inc;

  // Supply pins exist only so the wrapper matches the cell's pin list.
  wire unused_supply = VDD ^ VSS;

  assign accept   = START && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign mismatch = check_strobe && (ZN_IN != golden_zn(pat));
  assign err_inc  = (err_q == ERR_MAX) ? err_q : err_q + 1'b1;

  aoi22_bist_seq #(
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_seq (
    .clk_i          (CLK),
    .rst_ni         (RN),
    .load_i         (accept),
    .state_i        (state_q),
    .pat_o          (pat),
    .settle_done_o  (settle_done),
    .check_strobe_o (check_strobe),
    .last_o         (last_pat)
  );

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q      <= ST_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= '0;
      fail_seen_q  <= 1'b0;
      first_fail_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          // A restart from DONE clears the previous results on the accepting edge.
          if (accept) begin
            state_q      <= ST_SETTLE;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= '0;
            fail_seen_q  <= 1'b0;
            first_fail_q <= '0;
          end
        end
        ST_SETTLE: begin
          if (settle_done) state_q <= ST_CHECK;
        end
        ST_CHECK: begin
          if (mismatch) begin
            err_q <= err_inc;
            if (!fail_seen_q) begin
              fail_seen_q  <= 1'b1;
              first_fail_q <= pat;
            end
          end
          if (last_pat) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= ST_SETTLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign {A1, A2, B1, B2} = pat;
  assign BUSY       = busy_q;
  assign DONE       = done_q;
  assign PASS       = done_q && (err_q == '0);
  assign ERR_CNT    = err_q;
  assign FAIL_SEEN  = fail_seen_q;
  assign FIRST_FAIL = first_fail_q;

endmodule

// File: doc/gf180mcu_fd_sc_mcu9t5v0__aoi22_bist.md
Name: gf180mcu_fd_sc_mcu9t5v0__aoi22_bist

Overview:
Self-test sequencer that wraps one aoi22 cell instance. It is both the upstream pattern driver and the downstream response checker.
- Drives A1/A2/B1/B2 through all 16 input combinations.
- Waits a programmable settle time for each pattern, then samples the cell's ZN.
- Compares ZN against the golden AOI22 function, ZN = ~((A1&A2)|(B1&B2)).
- Reports a pass/fail summary.
It is used for silicon/characterisation test structures and gate-level regression of the cell.

Parameters:
- SETTLE_CYCLES, 2, cycles each pattern is held before ZN is sampled; legal range 1..15.
- ERR_W, 5, width of the mismatch counter; the counter saturates at 2^ERR_W-1.

Ports:
- CLK  input  1  rising-edge clock
- RN  input  1  asynchronous active-low reset
- START  input  1  run request; sampled only in IDLE and DONE
- ZN_IN  input  1  ZN output of the cell under test
- A1  output  1  cell stimulus
- A2  output  1  cell stimulus
- B1  output  1  cell stimulus
- B2  output  1  cell stimulus
- BUSY  output  1  high from START acceptance until the final check completes
- DONE  output  1  run complete; held until the next START or reset
- PASS  output  1  equals DONE && (ERR_CNT==0)
- ERR_CNT  output  ERR_W  saturating count of mismatching patterns
- FAIL_SEEN  output  1  at least one mismatch seen in the current run
- FIRST_FAIL  output  4  pattern index {A1,A2,B1,B2} of the first mismatch
- VDD  inout  1  supply, no logic function
- VSS  inout  1  ground, no logic function

Behaviour:
- Clocking and reset:
  - One clock, CLK. Asynchronous active-low reset RN.
  - While RN=0, all outputs are 0 and the state is IDLE.
- Pattern mapping: 4-bit counter pat, with {A1,A2,B1,B2} = pat[3:0]. All stimulus outputs come straight from flops, so they are glitch-free.
- Golden truth table: 16'h0777, bit i = expected ZN for pat=i.
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE:
  - If START=1: pat<=0, stimulus<=0, settle counter<=SETTLE_CYCLES-1, clear ERR_CNT/FAIL_SEEN/FIRST_FAIL, then go to SETTLE.
  - BUSY=1 from the cycle after acceptance.
- SETTLE:
  - Hold stimulus for exactly SETTLE_CYCLES cycles.
  - When the counter reaches 0, go to CHECK.
- CHECK (one cycle):
  - Sample ZN_IN and compare with golden[pat].
  - On mismatch: ERR_CNT increments (saturating). If FAIL_SEEN=0, set FIRST_FAIL<=pat and FAIL_SEEN<=1.
  - If pat==15: go to DONE, BUSY<=0, DONE<=1.
  - Otherwise: pat<=pat+1, stimulus updates the same edge, reload the settle counter, go to SETTLE.
- Latency:
  - Each pattern takes SETTLE_CYCLES+1 cycles.
  - DONE rises 16*(SETTLE_CYCLES+1) edges after the START-accepting edge (48 at default).
- DONE:
  - Results and stimulus (pattern 15) are held.
  - START=1 restarts exactly as from IDLE, clearing results on the same edge.
- START while BUSY is ignored. It is not queued.
- pat does not wrap. The run ends after index 15.
- Reset asserted mid-run aborts immediately: results are lost and stimulus returns to 0. After RN deasserts, the block waits in IDLE for START.
- ZN_IN is sampled only in CHECK; it is don't-care in every other state. It is treated as synchronous, because the settle time covers cell delay.

Decomposition:
- Package aoi22_bist_pkg holds:
  - the state enum (IDLE/SETTLE/CHECK/DONE, 2 bits);
  - localparam GOLDEN_ZN = 16'h0777;
  - localparam NUM_PAT = 16.
- One natural sub-module, aoi22_bist_seq: the pattern counter plus settle counter, with outputs pat and check_strobe.
- The top module holds the FSM, comparator and result registers.

Test Plan:
1. Reset: hold RN=0 with random START/ZN_IN -> all outputs 0. After release, outputs stay 0 and BUSY=0 until START.
2. Golden loop: ZN_IN from a behavioural aoi22; one-cycle START -> BUSY for 48 cycles; DONE=1, PASS=1, ERR_CNT=0, FAIL_SEEN=0; stimulus visits all 16 indices in order.
3. Stuck-at-1: ZN_IN=1 -> DONE at cycle 48, ERR_CNT=7, FIRST_FAIL=4'h3, FAIL_SEEN=1, PASS=0.
4. Stuck-at-0:
   - ZN_IN=0 -> ERR_CNT=9, FIRST_FAIL=4'h0.
   - Repeat with ERR_W=3 -> ERR_CNT saturates at 7.
   - Repeat with SETTLE_CYCLES=4 -> DONE at cycle 80.
5. Mid-run reset: pulse RN=0 at cycle 20 -> outputs 0 asynchronously. A new START then gives a clean pass in 48 cycles.
6. START handling:
   - START held high throughout the run -> no restart while BUSY.
   - START in DONE after a failing run -> ERR_CNT/FAIL_SEEN cleared on the accepting edge, and the new run passes.
